// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-cycle data memory.
// Build option LSU_MISALIGN_CHECK_EN rejects misaligned half/word requests.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic        req_err;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both 1; req_ready is high only while the unit is idle.
    assign req_ready = (state == IDLE);

    // Enables are held in flops but dropped at once while reset is asserted,
    // so an aborted access never reaches memory.
    assign mem_read  = mem_read_q & ~rst;
    assign mem_write = mem_write_q & ~rst;

    always_comb begin
        req_err = (req_size == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_size == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    always_comb begin
        lane8 = mem_read_data[7:0];
        case (off_q)
            2'd1:    lane8 = mem_read_data[15:8];
            2'd2:    lane8 = mem_read_data[23:16];
            2'd3:    lane8 = mem_read_data[31:24];
            default: lane8 = mem_read_data[7:0];
        endcase
        lane16 = off_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    end

    always_comb begin
        load_data = mem_read_data;
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & lane8[7]}}, lane8};
            2'b01:   load_data = {{16{~uns_q & lane16[15]}}, lane16};
            default: load_data = mem_read_data;
        endcase
    end

    // Read-modify-write: replace only the addressed lane of the fetched word.
    always_comb begin
        merged = mem_read_data;
        case (size_q)
            2'b00: begin
                case (off_q)
                    2'd0:    merged = {mem_read_data[31:8], wdata_q[7:0]};
                    2'd1:    merged = {mem_read_data[31:16], wdata_q[7:0], mem_read_data[7:0]};
                    2'd2:    merged = {mem_read_data[31:24], wdata_q[7:0], mem_read_data[15:0]};
                    default: merged = {wdata_q[7:0], mem_read_data[23:0]};
                endcase
            end
            2'b01:   merged = off_q[1] ? {wdata_q[15:0], mem_read_data[15:0]}
                                       : {mem_read_data[31:16], wdata_q[15:0]};
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_q           <= 1'b0;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            off_q          <= 2'b00;
            wdata_q        <= 32'h0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            mem_address    <= 16'h0;
            mem_write_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        off_q       <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        mem_address <= req_addr[17:2];
                        resp_rdata  <= 32'h0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state          <= ACCESS;
                            resp_err       <= 1'b0;
                            mem_read_q     <= ~req_write | (req_size != 2'b10);
                            mem_write_q    <= req_write & (req_size == 2'b10);
                            mem_write_data <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (wr_q && size_q != 2'b10) begin
                        mem_write_data <= merged;
                        mem_write_q    <= 1'b1;
                        state          <= WRITE;
                    end else begin
                        if (!wr_q)
                            resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    mem_write_q <= 1'b0;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and
// random requests checked against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Bench-side data memory: combinational read, write on rising edge.
    logic [31:0] mem [0:65535];
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

    logic [31:0] ref_mem [0:63];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference model: works on byte lanes with plain arithmetic.
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat, m_nrd, m_nwr;

    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [17:0] a, input logic [31:0] d);
        int     wi, nbytes, boff;
        logic   mis;
        longint v, full;
        wi    = int'(a[17:2]);
        mis   = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        m_err = (sz == 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
        m_err = m_err | mis;
`endif
        m_rd = 32'h0;
        if (m_err) begin
            m_lat = 1; m_nrd = 0; m_nwr = 0;
            return;
        end
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        boff   = (int'(a[1:0]) / nbytes) * nbytes;
        if (!w) begin
            full = longint'(1) << (8 * nbytes);
            v    = (longint'(ref_mem[wi]) >> (8 * boff)) % full;
            if (!u && v >= full / 2) v = v - full;
            m_rd  = v[31:0];
            m_lat = 2; m_nrd = 1; m_nwr = 0;
        end else begin
            for (int i = 0; i < nbytes; i++)
                ref_mem[wi][8*(boff+i) +: 8] = d[8*i +: 8];
            m_lat = (nbytes == 4) ? 2 : 3;
            m_nrd = (nbytes == 4) ? 0 : 1;
            m_nwr = 1;
        end
    endtask

    // Driver: presents one request, then keeps req_valid high with junk
    // fields while busy; collects what the DUT does until resp_valid.
    logic [31:0] got_rd;
    logic        got_err, got_busy_ready, got_both;
    int          got_lat, got_nrd, got_nwr;

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [17:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        got_lat = -1; got_rd = 32'hx; got_err = 1'bx;
        got_nrd = 0; got_nwr = 0; got_busy_ready = 1'b0; got_both = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = 18'($urandom); req_wdata = $urandom;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_read && mem_write) got_both = 1'b1;
            if (mem_read) got_nrd++;
            if (mem_write) got_nwr++;
            if (resp_valid) begin
                got_lat = i; got_rd = resp_rdata; got_err = resp_err;
                break;
            end
            if (req_ready) got_busy_ready = 1'b1;
            req_addr = 18'($urandom);
            req_size = 2'($urandom);
        end
        req_valid = 1'b0;
    endtask

    task automatic check_common(input string tag, input int wi);
        check({tag, "_nrd"}, 32'(got_nrd), 32'(m_nrd));
        check({tag, "_nwr"}, 32'(got_nwr), 32'(m_nwr));
        check({tag, "_busy_ready"}, {31'b0, got_busy_ready}, 32'd0);
        check({tag, "_rd_wr_both"}, {31'b0, got_both}, 32'd0);
        check({tag, "_mem"}, mem[wi], ref_mem[wi]);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [11];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 18'h0; req_wdata = 32'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
        end
        mem[0] = 32'hCAFEF00D; mem[3] = 32'h11223344;
        mem[5] = 32'h8899AABB; mem[8] = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

        vecs[0]  = '{1'b0, 2'd0, 1'b0, 18'h16, 32'h0, 32'hFFFFFF99, 1'b0, 2, 32'h8899AABB};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 18'h16, 32'h0, 32'h00000099, 1'b0, 2, 32'h8899AABB};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 18'h0D, 32'h000000EE, 32'h0, 1'b0, 3, 32'h1122EE44};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 18'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 18'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
`ifdef LSU_MISALIGN_CHECK_EN
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 18'h03, 32'h0, 32'h0, 1'b1, 1, 32'hCAFEF00D};
`else
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 18'h03, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 32'hCAFEF00D};
`endif
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 18'h14, 32'h0, 32'h0, 1'b1, 1, 32'h8899AABB};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 18'h16, 32'h0, 32'h00008899, 1'b0, 2, 32'h8899AABB};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 18'h0E, 32'h1234ABCD, 32'h0, 1'b0, 3, 32'hABCDEE44};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 18'h0C, 32'h55555555, 32'h0, 1'b1, 1, 32'hABCDEE44};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 18'h0F, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 32'hABCDEE44};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_mem_address", {16'h0, mem_address}, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        rst = 1'b0;

        // Directed vectors, issued back to back
        for (int k = 0; k < 11; k++) begin
            model(vecs[k].w, vecs[k].sz, vecs[k].u, vecs[k].addr, vecs[k].wdata);
            drive(vecs[k].w, vecs[k].sz, vecs[k].u, vecs[k].addr, vecs[k].wdata);
            check($sformatf("vec%0d_lat", k), 32'(got_lat), 32'(vecs[k].lat));
            check($sformatf("vec%0d_rdata", k), got_rd, vecs[k].rd);
            check($sformatf("vec%0d_err", k), {31'b0, got_err}, {31'b0, vecs[k].err});
            check($sformatf("vec%0d_word", k), mem[vecs[k].addr[17:2]], vecs[k].word);
            check_common($sformatf("vec%0d", k), int'(vecs[k].addr[17:2]));
        end

        // Reset during ACCESS of a half store aborts it
        mem[7] = 32'h55667788; ref_mem[7] = 32'h55667788;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 18'h1C; req_wdata = 32'h00009999;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_read_in_access", {31'b0, mem_read}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_read_forced", {31'b0, mem_read}, 32'd0);
        check("abort_write_forced", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (resp_valid || mem_write) seen++;
            end
            check("abort_quiet", 32'(seen), 32'd0);
        end
        check("abort_word", mem[7], 32'h55667788);

        // Random requests against the model
        for (int k = 0; k < 200; k++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [17:0] a;
            logic [31:0] d;
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            a  = 18'($urandom_range(0, 63));
            d  = $urandom;
            model(w, sz, u, a, d);
            drive(w, sz, u, a, d);
            check($sformatf("rnd%0d_lat", k), 32'(got_lat), 32'(m_lat));
            check($sformatf("rnd%0d_rdata", k), got_rd, m_rd);
            check($sformatf("rnd%0d_err", k), {31'b0, got_err}, {31'b0, m_err});
            check_common($sformatf("rnd%0d", k), int'(a[17:2]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
